// File: rtl/gt_int_serial_ctrl.sv
// gt_int_serial_ctrl: bit-serial A > B sequencer, DIGIT bits per SHIFT cycle, signed or unsigned.
// Defining GT_INT_SERIAL_EQ_EN adds an out_eq equality result alongside out_y.
module gt_int_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
`ifdef GT_INT_SERIAL_EQ_EN
    output logic             out_eq,
`endif
    output logic             busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0] cnt;
    logic sgn_q, a_msb, b_msb, gt, gt_n, y_q, last;
`ifdef GT_INT_SERIAL_EQ_EN
    logic eq, eq_n, eq_q;
    assign out_eq = eq_q;
`endif
    assign last = cnt == CW'(N - 1);
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign out_y = y_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (state == IDLE && in_valid)
            state_n = SHIFT;
        else if (state == SHIFT && last)
            state_n = DONE;
        else if (state == DONE && out_ready)
            state_n = IDLE;
    end
    // Operands shift right so the current digit always sits in the low DIGIT bits
    always_comb begin
        gt_n = gt;
`ifdef GT_INT_SERIAL_EQ_EN
        eq_n = eq;
`endif
        for (int i = 0; i < DIGIT; i++) begin
            gt_n = (a_q[i] & ~b_q[i]) | (~(a_q[i] ^ b_q[i]) & gt_n);
`ifdef GT_INT_SERIAL_EQ_EN
            eq_n = eq_n & ~(a_q[i] ^ b_q[i]);
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            sgn_q <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            gt <= 1'b0;
            cnt <= '0;
            y_q <= 1'b0;
`ifdef GT_INT_SERIAL_EQ_EN
            eq <= 1'b0;
            eq_q <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_q <= in_a;
                b_q <= in_b;
                sgn_q <= in_signed;
                a_msb <= in_a[WIDTH-1];
                b_msb <= in_b[WIDTH-1];
                gt <= 1'b0;
                cnt <= '0;
`ifdef GT_INT_SERIAL_EQ_EN
                eq <= 1'b1;
`endif
            end
        end else if (state == SHIFT) begin
            a_q <= a_q >> DIGIT;
            b_q <= b_q >> DIGIT;
            gt <= gt_n;
            cnt <= cnt + 1'b1;
`ifdef GT_INT_SERIAL_EQ_EN
            eq <= eq_n;
`endif
            if (last) begin
                // Differing signs decide a signed compare outright: the non-negative side wins
                y_q <= (sgn_q && a_msb != b_msb) ? b_msb : gt_n;
`ifdef GT_INT_SERIAL_EQ_EN
                eq_q <= eq_n;
`endif
            end
        end
    end
endmodule

// File: tb/tb_gt_int_serial_ctrl.sv
// tb_gt_int_serial_ctrl: scoreboard bench for gt_int_serial_ctrl (8/2 and 32/32 instances).
module tb_gt_int_serial_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;
    logic v8, rdy8, s8, ov8, or8, y8, bz8;
    logic [7:0] a8, b8;
    logic v32, rdy32, s32, ov32, or32, y32, bz32;
    logic [31:0] a32, b32;
`ifdef GT_INT_SERIAL_EQ_EN
    logic eq8, eq32;
`endif
    logic [1:0] q8[$];
    logic [1:0] q32[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gt_int_serial_ctrl #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_y(y8),
`ifdef GT_INT_SERIAL_EQ_EN
        .out_eq(eq8),
`endif
        .busy(bz8)
    );
    gt_int_serial_ctrl #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
        .in_signed(s32), .out_valid(ov32), .out_ready(or32), .out_y(y32),
`ifdef GT_INT_SERIAL_EQ_EN
        .out_eq(eq32),
`endif
        .busy(bz32)
    );

    // Returns {eq, gt} for a w-bit compare of the low w bits of a and b
    function automatic logic [1:0] model(input logic [31:0] a, b, input logic s, input int w);
        logic signed [31:0] sa, sb;
        logic [31:0] ua, ub;
        if (w == 8) begin
            ua = {24'b0, a[7:0]};
            ub = {24'b0, b[7:0]};
            sa = {{24{a[7]}}, a[7:0]};
            sb = {{24{b[7]}}, b[7:0]};
        end else begin
            ua = a;
            ub = b;
            sa = a;
            sb = b;
        end
        return {ua == ub, s ? (sa > sb) : (ua > ub)};
    endfunction

    task automatic test_reset;
        rst_n = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
        #3 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy8, ov8, y8, bz8} !== 4'b1000) $display("FAIL reset8: got %b expected 1000", {rdy8, ov8, y8, bz8});
        else pass_cnt++;
        total++;
        if ({rdy32, ov32, y32, bz32} !== 4'b1000) $display("FAIL reset32: got %b expected 1000", {rdy32, ov32, y32, bz32});
        else pass_cnt++;
`ifdef GT_INT_SERIAL_EQ_EN
        total++;
        if ({eq8, eq32} !== 2'b00) $display("FAIL reset_eq: got %b expected 00", {eq8, eq32});
        else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic txn8(input logic [7:0] a, b, input logic s, input string nm);
        int n, nb;
        logic [1:0] e;
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        q8.push_back(model({24'b0, a}, {24'b0, b}, s, 8));
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            if (n == 0) begin
                v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
            end
            n++;
            if (bz8) nb++;
        end while (!ov8 && n < 40);
        total++;
        if (n !== 5) $display("FAIL %s_latency: got %0d edges expected 5", nm, n);
        else pass_cnt++;
        e = (q8.size() > 0) ? q8.pop_front() : 2'bxx;
        total++;
        if (y8 !== e[0]) $display("FAIL %s_y: got %b expected %b", nm, y8, e[0]);
        else pass_cnt++;
`ifdef GT_INT_SERIAL_EQ_EN
        total++;
        if (eq8 !== e[1]) $display("FAIL %s_eq: got %b expected %b", nm, eq8, e[1]);
        else pass_cnt++;
`endif
        @(negedge clk);
        total++;
        if (nb + int'(bz8) !== 5) $display("FAIL %s_busy: got %0d cycles expected 5", nm, nb + int'(bz8));
        else pass_cnt++;
    endtask

    task automatic test_basic;
        txn8(8'h05, 8'h03, 1'b1, "basic");
    endtask

    task automatic test_signs;
        txn8(8'hFF, 8'h01, 1'b1, "ff_01_s");
        txn8(8'hFF, 8'h01, 1'b0, "ff_01_u");
        txn8(8'h80, 8'h7F, 1'b1, "80_7f_s");
        txn8(8'h80, 8'h7F, 1'b0, "80_7f_u");
        txn8(8'h80, 8'h80, 1'b1, "eq_80_s");
        txn8(8'h00, 8'h80, 1'b1, "00_80_s");
        txn8(8'h3C, 8'h3C, 1'b0, "eq_3c_u");
        txn8(8'h7E, 8'h7F, 1'b0, "7e_7f_u");
        for (int i = 0; i < 4; i++)
            txn8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    endtask

    task automatic test_backpressure;
        int n;
        logic [1:0] e;
        or8 = 1'b0;
        @(negedge clk);
        a8 = 8'h37; b8 = 8'h21; s8 = 1'b0; v8 = 1'b1;
        q8.push_back(model(32'h37, 32'h21, 1'b0, 8));
        n = 0;
        do begin
            @(negedge clk);
            v8 = 1'b0;
            n++;
        end while (!ov8 && n < 40);
        e = (q8.size() > 0) ? q8.pop_front() : 2'bxx;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({ov8, y8, rdy8} !== {1'b1, e[0], 1'b0})
                $display("FAIL hold_%0d: got v/y/rdy %b expected %b", c, {ov8, y8, rdy8}, {1'b1, e[0], 1'b0});
            else pass_cnt++;
            if (c == 1) begin
                a8 = 8'h01; b8 = 8'h02; s8 = 1'b0; v8 = 1'b1;
            end else v8 = 1'b0;
            @(negedge clk);
        end
        v8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        total++;
        if ({ov8, rdy8, y8} !== {1'b0, 1'b1, e[0]}) $display("FAIL release: got v/rdy/y %b expected %b", {ov8, rdy8, y8}, {1'b0, 1'b1, e[0]});
        else pass_cnt++;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov8 || bz8) n++;
        end
        total++;
        if (n !== 0) $display("FAIL stray_accept: got %0d busy cycles expected 0", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; s8 = 1'b1; v8 = 1'b1;
        q8.push_back(model(32'h55, 32'h11, 1'b1, 8));
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bz8 !== 1'b1) $display("FAIL mid_busy: got %b expected 1", bz8);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rdy8, ov8, bz8} !== 3'b100) $display("FAIL mid_reset: got rdy/v/busy %b expected 100", {rdy8, ov8, bz8});
        else pass_cnt++;
        void'(q8.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        txn8(8'h10, 8'h0F, 1'b1, "after_reset");
    endtask

    task automatic test_n1;
        int n;
        logic [1:0] e;
        @(negedge clk);
        a32 = 32'h8000_0000; b32 = 32'h7FFF_FFFF; s32 = 1'b0; v32 = 1'b1;
        q32.push_back(model(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32));
        n = 0;
        do begin
            @(negedge clk);
            v32 = 1'b0;
            n++;
        end while (!ov32 && n < 40);
        total++;
        if (n !== 2) $display("FAIL n1_latency: got %0d edges expected 2", n);
        else pass_cnt++;
        e = (q32.size() > 0) ? q32.pop_front() : 2'bxx;
        total++;
        if (y32 !== e[0]) $display("FAIL n1_y: got %b expected %b", y32, e[0]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc[6];
        int got;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int w;
                    @(negedge clk);
                    a32 = $urandom; b32 = (i == 2) ? a32 : $urandom; s32 = 1'($urandom); v32 = 1'b1;
                    w = 0;
                    while (!rdy32 && w < 20) begin
                        @(negedge clk);
                        w++;
                    end
                    q32.push_back(model(a32, b32, s32, 32));
                    acc[i] = cyc;
                end
                @(negedge clk);
                v32 = 1'b0;
            end
            begin
                logic [1:0] e;
                got = 0;
                for (int t = 0; t < 100 && got < 6; t++) begin
                    @(negedge clk);
                    if (ov32) begin
                        e = (q32.size() > 0) ? q32.pop_front() : 2'bxx;
                        total++;
                        if (y32 !== e[0]) $display("FAIL b2b_y_%0d: got %b expected %b", got, y32, e[0]);
                        else pass_cnt++;
`ifdef GT_INT_SERIAL_EQ_EN
                        total++;
                        if (eq32 !== e[1]) $display("FAIL b2b_eq_%0d: got %b expected %b", got, eq32, e[1]);
                        else pass_cnt++;
`endif
                        got++;
                    end
                end
            end
        join
        total++;
        if (got !== 6) $display("FAIL b2b_count: got %0d results expected 6", got);
        else pass_cnt++;
        for (int i = 1; i < 6; i++) begin
            total++;
            if (acc[i] - acc[i-1] !== 3) $display("FAIL b2b_spacing_%0d: got %0d cycles expected 3", i, acc[i] - acc[i-1]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_backpressure();
        test_reset_mid();
        test_n1();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
